// File: rtl/axi_lite_apb_bridge.sv
// AXI4-Lite slave to APB4 master bridge.
// One APB access per AXI transaction, one transaction in flight at a time.
// Reads and writes that collide in IDLE are granted alternately, and an APB
// access stuck without pready_i is abandoned with SLVERR.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | no APB access; waiting for a complete write or a read
// S_SETUP  | APB setup phase (psel=1, penable=0)
// S_ACCESS | APB access phase (psel=1, penable=1), waiting for pready
// S_WRESP  | write response held on B until b_ready_i
// S_RRESP  | read response held on R until r_ready_i
module axi_lite_apb_bridge #(
  parameter int AXI_AW         = 16,
  parameter int AXI_DW         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [AXI_AW-1:0]     aw_addr_i,
  input  logic                  aw_valid_i,
  output logic                  aw_ready_o,
  input  logic [AXI_DW-1:0]     w_data_i,
  input  logic [AXI_DW/8-1:0]   w_strb_i,
  input  logic                  w_valid_i,
  output logic                  w_ready_o,
  output logic [1:0]            b_resp_o,
  output logic                  b_valid_o,
  input  logic                  b_ready_i,
  input  logic [AXI_AW-1:0]     ar_addr_i,
  input  logic                  ar_valid_i,
  output logic                  ar_ready_o,
  output logic [AXI_DW-1:0]     r_data_o,
  output logic [1:0]            r_resp_o,
  output logic                  r_valid_o,
  input  logic                  r_ready_i,
  output logic [AXI_AW-1:0]     paddr_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [AXI_DW-1:0]     pwdata_o,
  output logic [AXI_DW/8-1:0]   pstrb_o,
  input  logic [AXI_DW-1:0]     prdata_i,
  input  logic                  pready_i,
  input  logic                  pslverr_i
);

  localparam int SW    = AXI_DW / 8;
  localparam int CW    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ACCESS = 3'd2,
    S_WRESP  = 3'd3,
    S_RRESP  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic              aw_full_q, aw_full_d;
  logic [AXI_AW-1:0] aw_addr_q, aw_addr_d;
  logic              w_full_q, w_full_d;
  logic [AXI_DW-1:0] w_data_q, w_data_d;
  logic [SW-1:0]     w_strb_q, w_strb_d;
  logic              ar_full_q, ar_full_d;
  logic [AXI_AW-1:0] ar_addr_q, ar_addr_d;
  logic              last_wr_q, last_wr_d;
  logic [AXI_AW-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [AXI_DW-1:0] pwdata_q, pwdata_d;
  logic [SW-1:0]     pstrb_q, pstrb_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        b_resp_q, b_resp_d;
  logic [1:0]        r_resp_q, r_resp_d;
  logic [AXI_DW-1:0] r_data_q, r_data_d;

  logic       aw_hs, w_hs, ar_hs;
  logic       wr_pend, rd_pend, tie;
  logic       grant_wr, grant_rd;
  logic       timeout;
  logic [1:0] apb_resp;

  assign aw_ready_o = ~aw_full_q;
  assign w_ready_o  = ~w_full_q;
  assign ar_ready_o = ~ar_full_q;

  assign aw_hs = aw_valid_i & ~aw_full_q;
  assign w_hs  = w_valid_i & ~w_full_q;
  assign ar_hs = ar_valid_i & ~ar_full_q;

  // A request handshaking this cycle counts as pending, so IDLE can launch
  // SETUP on the very next edge without first parking it in a holding register.
  assign wr_pend  = (aw_full_q | aw_valid_i) & (w_full_q | w_valid_i);
  assign rd_pend  = ar_full_q | ar_valid_i;
  assign tie      = wr_pend & rd_pend;
  assign grant_wr = wr_pend & (~rd_pend | ~last_wr_q);
  assign grant_rd = rd_pend & ~grant_wr;

  assign timeout  = TO_EN && !pready_i && (cnt_q == CW'(1));
  assign apb_resp = pslverr_i ? 2'b10 : 2'b00;

  assign psel_o    = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign penable_o = (state_q == S_ACCESS);
  assign b_valid_o = (state_q == S_WRESP);
  assign r_valid_o = (state_q == S_RRESP);
  assign paddr_o   = paddr_q;
  assign pwrite_o  = pwrite_q;
  assign pwdata_o  = pwdata_q;
  assign pstrb_o   = pstrb_q;
  assign b_resp_o  = b_resp_q;
  assign r_resp_o  = r_resp_q;
  assign r_data_o  = r_data_q;

  // Next-state: holding-register capture, arbitration, APB sequencing, responses.
  always_comb begin
    state_d   = state_q;
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    ar_full_d = ar_full_q;
    ar_addr_d = ar_addr_q;
    last_wr_d = last_wr_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    cnt_d     = cnt_q;
    b_resp_d  = b_resp_q;
    r_resp_d  = r_resp_q;
    r_data_d  = r_data_q;

    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_addr_d = aw_addr_i;
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = w_data_i;
      w_strb_d = w_strb_i;
    end
    if (ar_hs) begin
      ar_full_d = 1'b1;
      ar_addr_d = ar_addr_i;
    end

    unique case (state_q)
      S_IDLE: begin
        // The alternation flag only moves on a real collision, so a lone
        // request never steals the next tie-break from the other direction.
        if (grant_wr) begin
          state_d   = S_SETUP;
          aw_full_d = 1'b0;
          w_full_d  = 1'b0;
          paddr_d   = aw_full_q ? aw_addr_q : aw_addr_i;
          pwrite_d  = 1'b1;
          pwdata_d  = w_full_q ? w_data_q : w_data_i;
          pstrb_d   = w_full_q ? w_strb_q : w_strb_i;
          cnt_d     = CW'(TIMEOUT_CYCLES);
          if (tie) last_wr_d = 1'b1;
        end else if (grant_rd) begin
          state_d   = S_SETUP;
          ar_full_d = 1'b0;
          paddr_d   = ar_full_q ? ar_addr_q : ar_addr_i;
          pwrite_d  = 1'b0;
          pwdata_d  = '0;
          pstrb_d   = '0;
          cnt_d     = CW'(TIMEOUT_CYCLES);
          if (tie) last_wr_d = 1'b0;
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (pready_i) begin
          if (pwrite_q) begin
            state_d  = S_WRESP;
            b_resp_d = apb_resp;
          end else begin
            state_d  = S_RRESP;
            r_resp_d = apb_resp;
            r_data_d = prdata_i;
          end
        end else if (timeout) begin
          if (pwrite_q) begin
            state_d  = S_WRESP;
            b_resp_d = 2'b10;
          end else begin
            state_d  = S_RRESP;
            r_resp_d = 2'b10;
            r_data_d = '0;
          end
        end else if (TO_EN) begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_WRESP: begin
        if (b_ready_i) state_d = S_IDLE;
      end
      S_RRESP: begin
        if (r_ready_i) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight transaction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      ar_full_q <= 1'b0;
      ar_addr_q <= '0;
      last_wr_q <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      cnt_q     <= '0;
      b_resp_q  <= 2'b00;
      r_resp_q  <= 2'b00;
      r_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      ar_full_q <= ar_full_d;
      ar_addr_q <= ar_addr_d;
      last_wr_q <= last_wr_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      cnt_q     <= cnt_d;
      b_resp_q  <= b_resp_d;
      r_resp_q  <= r_resp_d;
      r_data_q  <= r_data_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_apb_bridge.sv
// Self-checking bench for axi_lite_apb_bridge, built with a 4-cycle timeout.
module tb_axi_lite_apb_bridge;

  localparam int TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [15:0] aw_addr_i = '0;
  logic        aw_valid_i = 1'b0;
  logic        aw_ready_o;
  logic [31:0] w_data_i = '0;
  logic [3:0]  w_strb_i = '0;
  logic        w_valid_i = 1'b0;
  logic        w_ready_o;
  logic [1:0]  b_resp_o;
  logic        b_valid_o;
  logic        b_ready_i = 1'b0;
  logic [15:0] ar_addr_i = '0;
  logic        ar_valid_i = 1'b0;
  logic        ar_ready_o;
  logic [31:0] r_data_o;
  logic [1:0]  r_resp_o;
  logic        r_valid_o;
  logic        r_ready_i = 1'b0;
  logic [15:0] paddr_o;
  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [31:0] pwdata_o;
  logic [3:0]  pstrb_o;
  logic [31:0] prdata_i = '0;
  logic        pready_i = 1'b0;
  logic        pslverr_i = 1'b0;

  int total = 0;
  int bad   = 0;

  axi_lite_apb_bridge #(.AXI_AW(16), .AXI_DW(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .aw_addr_i(aw_addr_i), .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
    .w_data_i(w_data_i), .w_strb_i(w_strb_i), .w_valid_i(w_valid_i), .w_ready_o(w_ready_o),
    .b_resp_o(b_resp_o), .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
    .ar_addr_i(ar_addr_i), .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o),
    .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
    .paddr_o(paddr_o), .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
    .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wd;
    logic [3:0]  st;
    int          waits;
    logic        err;
    logic [31:0] prd;
    logic [1:0]  eresp;
    logic [31:0] erd;
  } vec_t;

  vec_t        vecs[7];
  logic [31:0] mem[8];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Present one request in the current cycle; returns one edge later.
  task automatic issue(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                       input logic [3:0] st);
    if (wr) begin
      chk("aw_ready_idle", 32'(aw_ready_o), 32'd1);
      chk("w_ready_idle", 32'(w_ready_o), 32'd1);
      aw_valid_i = 1'b1; aw_addr_i = addr;
      w_valid_i = 1'b1;  w_data_i = wd; w_strb_i = st;
    end else begin
      chk("ar_ready_idle", 32'(ar_ready_o), 32'd1);
      ar_valid_i = 1'b1; ar_addr_i = addr;
    end
    tick();
    aw_valid_i = 1'b0; w_valid_i = 1'b0; ar_valid_i = 1'b0;
  endtask

  // Called in the SETUP cycle: plays the APB slave with 'waits' low-pready
  // cycles, then checks the AXI response and its handshake.
  task automatic complete(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                          input logic [3:0] st, input int waits, input logic err,
                          input logic [31:0] prd, input logic [1:0] eresp,
                          input logic [31:0] erd);
    int n;
    int exp_n;
    chk("setup_psel", 32'(psel_o), 32'd1);
    chk("setup_penable", 32'(penable_o), 32'd0);
    chk("pwrite", 32'(pwrite_o), 32'(wr));
    chk("paddr", 32'(paddr_o), 32'(addr));
    chk("pwdata", pwdata_o, wr ? wd : 32'h0);
    chk("pstrb", 32'(pstrb_o), 32'(wr ? st : 4'h0));
    pready_i = 1'b1;
    tick();
    n = 0;
    while (psel_o && n < 20) begin
      chk("access_penable", 32'(penable_o), 32'd1);
      chk("access_paddr", 32'(paddr_o), 32'(addr));
      chk("access_pwdata", pwdata_o, wr ? wd : 32'h0);
      pready_i  = (n >= waits);
      prdata_i  = prd;
      pslverr_i = err;
      tick();
      n++;
    end
    pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = $urandom;
    exp_n = (waits >= TO) ? TO : waits + 1;
    chk("access_cycles", 32'(n), 32'(exp_n));
    for (int k = 0; k < 2; k++) begin
      if (wr) begin
        chk("b_valid", 32'(b_valid_o), 32'd1);
        chk("b_resp", 32'(b_resp_o), 32'(eresp));
        chk("r_valid_quiet", 32'(r_valid_o), 32'd0);
      end else begin
        chk("r_valid", 32'(r_valid_o), 32'd1);
        chk("r_resp", 32'(r_resp_o), 32'(eresp));
        chk("r_data", r_data_o, erd);
        chk("b_valid_quiet", 32'(b_valid_o), 32'd0);
      end
      if (k == 1) begin
        b_ready_i = wr; r_ready_i = ~wr;
      end
      tick();
    end
    b_ready_i = 1'b0; r_ready_i = 1'b0;
    chk("resp_done", 32'(wr ? b_valid_o : r_valid_o), 32'd0);
  endtask

  task automatic run_txn(input vec_t v);
    issue(v.wr, v.addr, v.wd, v.st);
    complete(v.wr, v.addr, v.wd, v.st, v.waits, v.err, v.prd, v.eresp, v.erd);
  endtask

  task automatic arb_round(input logic exp_write_first);
    aw_valid_i = 1'b1; aw_addr_i = 16'h0030;
    w_valid_i = 1'b1;  w_data_i = 32'hA0A0B0B0; w_strb_i = 4'hF;
    ar_valid_i = 1'b1; ar_addr_i = 16'h0034;
    tick();
    aw_valid_i = 1'b0; w_valid_i = 1'b0; ar_valid_i = 1'b0;
    chk("arb_first_is_write", 32'(pwrite_o), 32'(exp_write_first));
    if (exp_write_first) begin
      chk("arb_ar_held", 32'(ar_ready_o), 32'd0);
      complete(1'b1, 16'h0030, 32'hA0A0B0B0, 4'hF, 0, 1'b0, 32'h0, 2'b00, 32'h0);
      tick();
      complete(1'b0, 16'h0034, 32'h0, 4'h0, 1, 1'b0, 32'h13572468, 2'b00, 32'h13572468);
    end else begin
      chk("arb_aw_held", 32'(aw_ready_o), 32'd0);
      complete(1'b0, 16'h0034, 32'h0, 4'h0, 0, 1'b0, 32'h0BADF00D, 2'b00, 32'h0BADF00D);
      tick();
      complete(1'b1, 16'h0030, 32'hA0A0B0B0, 4'hF, 2, 1'b0, 32'h0, 2'b00, 32'h0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench hung");
  end

  initial begin
    vecs[0] = '{1'b1, 16'h0040, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0,        2'b00, 32'h0};
    vecs[1] = '{1'b0, 16'h0010, 32'h0,        4'h0, 3, 1'b1, 32'h12345678, 2'b10, 32'h12345678};
    vecs[2] = '{1'b1, 16'h0100, 32'h11112222, 4'hC, 4, 1'b0, 32'h0,        2'b10, 32'h0};
    vecs[3] = '{1'b0, 16'h0104, 32'h0,        4'h0, 0, 1'b0, 32'hCAFEF00D, 2'b00, 32'hCAFEF00D};
    vecs[4] = '{1'b0, 16'h0200, 32'h0,        4'h0, 9, 1'b0, 32'h00000055, 2'b10, 32'h0};
    vecs[5] = '{1'b1, 16'h0008, 32'h00A5A5A5, 4'h5, 2, 1'b1, 32'h0,        2'b10, 32'h0};
    vecs[6] = '{1'b1, 16'hFFFC, 32'h76543210, 4'h1, 1, 1'b0, 32'h0,        2'b00, 32'h0};

    #3;
    chk("rst_psel", 32'(psel_o), 32'd0);
    chk("rst_penable", 32'(penable_o), 32'd0);
    chk("rst_pwrite", 32'(pwrite_o), 32'd0);
    chk("rst_bvalid", 32'(b_valid_o), 32'd0);
    chk("rst_rvalid", 32'(r_valid_o), 32'd0);
    chk("rst_paddr", 32'(paddr_o), 32'd0);
    chk("rst_pwdata", pwdata_o, 32'd0);
    chk("rst_pstrb", 32'(pstrb_o), 32'd0);
    chk("rst_rdata", r_data_o, 32'd0);
    chk("rst_resps", 32'({b_resp_o, r_resp_o}), 32'd0);
    chk("rst_readys", 32'({aw_ready_o, w_ready_o, ar_ready_o}), 32'h7);
    #9 rst_ni = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_txn(vecs[i]);

    // Split write: AW alone must not start an APB access.
    aw_valid_i = 1'b1; aw_addr_i = 16'h0044;
    tick();
    aw_valid_i = 1'b0;
    for (int c = 1; c < 5; c++) begin
      chk("split_no_psel", 32'(psel_o), 32'd0);
      chk("split_aw_held", 32'(aw_ready_o), 32'd0);
      tick();
    end
    chk("split_no_psel_c5", 32'(psel_o), 32'd0);
    w_valid_i = 1'b1; w_data_i = 32'h0000BEEF; w_strb_i = 4'h3;
    tick();
    w_valid_i = 1'b0;
    complete(1'b1, 16'h0044, 32'h0000BEEF, 4'h3, 0, 1'b0, 32'h0, 2'b00, 32'h0);

    arb_round(1'b1);
    arb_round(1'b0);

    // Reset in the middle of an ACCESS phase, with a read also parked.
    issue(1'b1, 16'h0020, 32'h5555AAAA, 4'hF);
    pready_i = 1'b0;
    tick();
    chk("mid_access", 32'(penable_o), 32'd1);
    ar_valid_i = 1'b1; ar_addr_i = 16'h0024;
    tick();
    ar_valid_i = 1'b0;
    chk("mid_ar_held", 32'(ar_ready_o), 32'd0);
    rst_ni = 1'b0;
    #1;
    chk("arst_psel", 32'(psel_o), 32'd0);
    chk("arst_penable", 32'(penable_o), 32'd0);
    chk("arst_bvalid", 32'(b_valid_o), 32'd0);
    chk("arst_readys", 32'({aw_ready_o, w_ready_o, ar_ready_o}), 32'h7);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    chk("post_rst_idle", 32'(psel_o), 32'd0);
    run_txn('{1'b0, 16'h0028, 32'h0, 4'h0, 1, 1'b0, 32'h600DF00D, 2'b00, 32'h600DF00D});

    // Randomized traffic against a word-array slave model.
    for (int i = 0; i < 8; i++) mem[i] = 32'h0;
    for (int it = 0; it < 40; it++) begin
      vec_t        v;
      logic [2:0]  idx;
      logic        tmo;
      logic [31:0] nv;
      idx     = 3'($urandom_range(0, 7));
      v.wr    = 1'($urandom_range(0, 1));
      v.addr  = 16'(idx) << 2;
      v.wd    = $urandom;
      v.st    = 4'($urandom_range(0, 15));
      v.waits = $urandom_range(0, 5);
      v.err   = ($urandom_range(0, 5) == 0);
      tmo     = (v.waits >= TO);
      v.prd   = mem[idx];
      v.eresp = (tmo || v.err) ? 2'b10 : 2'b00;
      v.erd   = (v.wr || tmo) ? 32'h0 : mem[idx];
      run_txn(v);
      if (v.wr && !tmo && !v.err) begin
        nv = mem[idx];
        for (int b = 0; b < 4; b++)
          if (v.st[b]) nv[b*8 +: 8] = v.wd[b*8 +: 8];
        mem[idx] = nv;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
